// File: rtl/glitch_loader_if.sv
// Host-side byte stream, UART response and command FIFO write signals of glitch_loader.
interface glitch_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        glitch_ready;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_we;
    logic [31:0] fifo_out;
    logic        fifo_clr;
    logic        busy;

    modport master (
        output rx_data, rx_valid, tx_busy, glitch_ready, fifo_empty, fifo_full,
        input  tx_data, tx_valid, fifo_we, fifo_out, fifo_clr, busy
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy, glitch_ready, fifo_empty, fifo_full,
        output tx_data, tx_valid, fifo_we, fifo_out, fifo_clr, busy
    );
endinterface

// File: rtl/glitch_loader.sv
// Validates framed load packets from the host UART, writes glitch words into the
// command FIFO, pads it with no-op words until full and answers with ACK/NAK.
module glitch_loader #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 50000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
    input logic            clk_in,
    input logic            rst,
    glitch_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_PAD, S_WAITF, S_RESP, S_DRAIN
    } state_t;

    localparam logic [7:0]  DEPTH_B = 8'(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  wcnt_q;
    logic [1:0]  bidx_q;
    logic [23:0] buf_q;
    logic [15:0] to_q;
    logic [7:0]  resp_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        fifo_we_q;
    logic        fifo_clr_q;
    logic [31:0] fifo_out_q;
    logic        to_hit;

    assign to_hit       = (to_q == TO_LAST);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.fifo_we  = fifo_we_q;
    assign bus.fifo_clr = fifo_clr_q;
    assign bus.fifo_out = fifo_out_q;
    assign bus.busy     = (state_q != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            bidx_q     <= '0;
            buf_q      <= '0;
            to_q       <= '0;
            resp_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            fifo_we_q  <= 1'b0;
            fifo_clr_q <= 1'b0;
            fifo_out_q <= '0;
        end else begin
            fifo_we_q  <= 1'b0;
            fifo_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        to_q <= '0;
                        if (bus.glitch_ready && bus.fifo_empty) begin
                            state_q <= S_COUNT;
                        end else begin
                            resp_q  <= NAK_BYTE;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_COUNT: begin
                    if (bus.rx_valid) begin
                        to_q <= '0;
                        if (bus.rx_data == 8'd0 || bus.rx_data > DEPTH_B) begin
                            resp_q  <= NAK_BYTE;
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_q   <= bus.rx_data;
                            wcnt_q  <= '0;
                            bidx_q  <= '0;
                            state_q <= S_DATA;
                        end
                    end else if (to_hit) begin
                        fifo_clr_q <= 1'b1;
                        tx_data_q  <= NAK_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        to_q <= '0;
                        if (bidx_q != 2'd3) begin
                            buf_q  <= {buf_q[15:0], bus.rx_data};
                            bidx_q <= bidx_q + 2'd1;
                        end else begin
                            bidx_q <= '0;
                            if (bus.fifo_full) begin
                                fifo_clr_q <= 1'b1;
                                resp_q     <= NAK_BYTE;
                                state_q    <= S_DRAIN;
                            end else begin
                                fifo_we_q  <= 1'b1;
                                fifo_out_q <= {buf_q, bus.rx_data};
                                wcnt_q     <= wcnt_q + 8'd1;
                                // last word still settles through WAITF so PAD sees the updated fifo_full
                                if (wcnt_q + 8'd1 == cnt_q) begin
                                    state_q <= S_WAITF;
                                end
                            end
                        end
                    end else if (to_hit) begin
                        fifo_clr_q <= 1'b1;
                        tx_data_q  <= NAK_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                S_PAD: begin
                    if (!bus.fifo_full) begin
                        fifo_we_q  <= 1'b1;
                        fifo_out_q <= '0;
                        state_q    <= S_WAITF;
                    end else begin
                        tx_data_q  <= ACK_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end
                S_WAITF: state_q <= S_PAD;
                S_RESP: begin
                    if (!bus.tx_busy) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.rx_valid) begin
                        to_q <= '0;
                    end else if (to_hit) begin
                        tx_data_q  <= resp_q;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
